// File: rtl/alu_seq_ctrl_if.sv
// rtl/alu_seq_ctrl_if.sv - instruction, register-file and ALU bus of the execute sequencer
interface alu_seq_ctrl_if #(
  parameter int REG_AW = 3
);
  logic              i_valid;
  logic              o_ready;
  logic [2:0]        i_op;
  logic [REG_AW-1:0] i_rd;
  logic [REG_AW-1:0] i_rn;
  logic [31:0]       i_imm;
  logic              i_abort;
  logic [REG_AW-1:0] o_rf_raddr;
  logic [31:0]       i_rf_rdata;
  logic              o_rf_we;
  logic [REG_AW-1:0] o_rf_waddr;
  logic [31:0]       o_rf_wdata;
  logic [2:0]        o_alu_sel;
  logic [31:0]       o_alu_imm;
  logic [31:0]       o_alu_rn;
  logic [31:0]       i_alu_result;
  logic [3:0]        i_alu_apsr;
  logic [3:0]        o_apsr;
  logic              o_done;
  logic              o_err;

  modport slave (
    input  i_valid, i_op, i_rd, i_rn, i_imm, i_abort, i_rf_rdata, i_alu_result, i_alu_apsr,
    output o_ready, o_rf_raddr, o_rf_we, o_rf_waddr, o_rf_wdata, o_alu_sel, o_alu_imm,
           o_alu_rn, o_apsr, o_done, o_err
  );

  modport master (
    output i_valid, i_op, i_rd, i_rn, i_imm, i_abort, i_rf_rdata, i_alu_result, i_alu_apsr,
    input  o_ready, o_rf_raddr, o_rf_we, o_rf_waddr, o_rf_wdata, o_alu_sel, o_alu_imm,
           o_alu_rn, o_apsr, o_done, o_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - multi-cycle execute-stage sequencer for the 32-bit integer ALU
module alu_seq_ctrl #(
  parameter int REG_AW = 3
) (
  input logic          i_clk,
  input logic          i_rst_n,
  alu_seq_ctrl_if.slave bus
);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MOVI = 3'b001;
  localparam logic [2:0] OP_MOVR = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rn_q;
  logic [31:0]       imm_q;
  logic [31:0]       res_q;
  logic [3:0]        flags_q;
  logic [3:0]        apsr_q;
  logic [2:0]        alu_sel_q;
  logic [31:0]       alu_imm_q;
  logic [31:0]       alu_rn_q;
  logic              idle_q;
  logic              done_q;
  logic              err_q;
  logic              we_q;
  logic              accept;

  function automatic logic [2:0] alu_sel_of(input logic [2:0] op);
    return (op == OP_CMP) ? OP_SUB : op;
  endfunction

  // idle_q holds ready low for the first cycle after reset release
  assign accept = idle_q && !bus.i_abort && bus.i_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      rn_q      <= '0;
      imm_q     <= '0;
      res_q     <= '0;
      flags_q   <= '0;
      apsr_q    <= '0;
      alu_sel_q <= '0;
      alu_imm_q <= '0;
      alu_rn_q  <= '0;
      idle_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      idle_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      alu_sel_q <= '0;
      alu_imm_q <= '0;
      alu_rn_q  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.i_op;
            rd_q  <= bus.i_rd;
            rn_q  <= bus.i_rn;
            imm_q <= bus.i_imm;
            case (bus.i_op)
              OP_MOVI: begin
                state     <= EXEC;
                alu_sel_q <= OP_MOVI;
                alu_imm_q <= bus.i_imm;
              end
              OP_ADD, OP_SUB, OP_MOVR, OP_CMP: state <= READ;
              default: begin
                state <= ERR;
                err_q <= 1'b1;
              end
            endcase
          end else begin
            idle_q <= 1'b1;
          end
        end
        READ: begin
          if (bus.i_abort) begin
            state  <= IDLE;
            idle_q <= 1'b1;
          end else begin
            state     <= EXEC;
            alu_sel_q <= alu_sel_of(op_q);
            alu_imm_q <= imm_q;
            alu_rn_q  <= bus.i_rf_rdata;
          end
        end
        EXEC: begin
          if (bus.i_abort) begin
            state  <= IDLE;
            idle_q <= 1'b1;
          end else begin
            state   <= WB;
            res_q   <= bus.i_alu_result;
            flags_q <= bus.i_alu_apsr;
            done_q  <= 1'b1;
            we_q    <= (op_q != OP_CMP);
          end
        end
        WB: begin
          state  <= IDLE;
          idle_q <= 1'b1;
          if (!bus.i_abort && (op_q == OP_ADD || op_q == OP_SUB || op_q == OP_CMP))
            apsr_q <= flags_q;
        end
        ERR: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          idle_q <= 1'b1;
        end
      endcase
    end
  end

  // Address follows i_rn while idle so a registered RF returns data during READ
  assign bus.o_rf_raddr = (state == IDLE) ? bus.i_rn : rn_q;
  assign bus.o_ready    = idle_q && !bus.i_abort;
  assign bus.o_rf_we    = we_q && !bus.i_abort;
  assign bus.o_rf_waddr = rd_q;
  assign bus.o_rf_wdata = res_q;
  assign bus.o_alu_sel  = alu_sel_q;
  assign bus.o_alu_imm  = alu_imm_q;
  assign bus.o_alu_rn   = alu_rn_q;
  assign bus.o_apsr     = apsr_q;
  assign bus.o_done     = done_q && !bus.i_abort;
  assign bus.o_err      = err_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;
  localparam int AW = 3;
  localparam logic [2:0] ADD = 3'b000, MOVI = 3'b001, MOVR = 3'b010, SUB = 3'b101, CMP = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;

  alu_seq_ctrl_if #(.REG_AW(AW)) bus ();
  alu_seq_ctrl #(.REG_AW(AW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Register file environment: synchronous read, one-cycle read latency
  logic [31:0] rf [2**AW];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**AW; i++) rf[i] <= '0;
    end else if (bus.o_rf_we) begin
      rf[bus.o_rf_waddr] <= bus.o_rf_wdata;
    end
    bus.i_rf_rdata <= rf[bus.o_rf_raddr];
  end

  // ALU environment
  always_comb begin
    logic [32:0] s;
    bus.i_alu_result = '0;
    bus.i_alu_apsr   = '0;
    s = '0;
    case (bus.o_alu_sel)
      3'b000: begin
        s = {1'b0, bus.o_alu_rn} + {1'b0, bus.o_alu_imm};
        bus.i_alu_result = s[31:0];
        bus.i_alu_apsr = {s[31], s[31:0] == 0, s[32],
                          (bus.o_alu_rn[31] == bus.o_alu_imm[31]) && (s[31] != bus.o_alu_rn[31])};
      end
      3'b101: begin
        s = {1'b0, bus.o_alu_rn} - {1'b0, bus.o_alu_imm};
        bus.i_alu_result = s[31:0];
        bus.i_alu_apsr = {s[31], s[31:0] == 0, ~s[32],
                          (bus.o_alu_rn[31] != bus.o_alu_imm[31]) && (s[31] != bus.o_alu_rn[31])};
      end
      3'b001: begin
        bus.i_alu_result = bus.o_alu_imm;
        bus.i_alu_apsr = {bus.o_alu_imm[31], bus.o_alu_imm == 0, 2'b00};
      end
      3'b010: begin
        bus.i_alu_result = bus.o_alu_rn;
        bus.i_alu_apsr = {bus.o_alu_rn[31], bus.o_alu_rn == 0, 2'b00};
      end
      default: ;
    endcase
  end

  // Reference arithmetic: returns {N,Z,C,V, result}
  function automatic logic [35:0] ref_exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ua = {32'b0, a};
    longint ub = {32'b0, b};
    longint s = 0;
    logic [31:0] r = '0;
    logic c = 1'b0;
    logic v;
    case (op)
      ADD: begin r = a + b; s = sa + sb; c = (ua + ub) > 64'hFFFF_FFFF; end
      SUB, CMP: begin r = a - b; s = sa - sb; c = (ua >= ub); end
      MOVI: r = b;
      MOVR: r = a;
      default: ;
    endcase
    v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r[31], r == 0, c, v, r};
  endfunction

  // Behavioural model: one pending instruction with its retire cycle.
  // Cycle numbering here counts posedges, so the retire cycle is one less than
  // the spec's "k+n" (ADD-class +2, MOVI +1, illegal +0 after the accept edge).
  logic [31:0] mrf [2**AW];
  logic [3:0]  m_apsr = '0;
  bit          p_v = 0, p_legal, p_we, p_upd;
  int          p_k, p_ret, ready_from = 0;
  logic [AW-1:0] p_rd;
  logic [31:0] p_data, p_imm, p_rnv;
  logic [2:0]  p_sel;
  logic [3:0]  p_apsr;
  int          wr_count = 0;
  logic [31:0] last_wdata = '0;
  logic [AW-1:0] last_waddr = '0;

  always @(negedge clk) begin
    bit busy, e_ready, e_done, e_err, e_we, in_exec;
    logic [35:0] rx;
    if (!rst_n) begin
      chk("rst_ready", bus.o_ready, 0);
      chk("rst_we", bus.o_rf_we, 0);
      chk("rst_done", bus.o_done, 0);
      chk("rst_err", bus.o_err, 0);
      chk("rst_apsr", bus.o_apsr, 0);
      m_apsr = '0;
      p_v = 0;
      ready_from = cyc + 2;
      for (int i = 0; i < 2**AW; i++) mrf[i] = '0;
    end else begin
      busy    = p_v && (cyc >= p_k);
      e_ready = !busy && (cyc >= ready_from) && !bus.i_abort;
      e_done  = 0; e_err = 0; e_we = 0;
      if (busy && cyc == p_ret) begin
        if (!p_legal) e_err = 1;
        else if (!bus.i_abort) begin e_done = 1; e_we = p_we; end
      end
      in_exec = busy && p_legal && (cyc == p_ret - 1);
      chk("ready", bus.o_ready, e_ready);
      chk("done", bus.o_done, e_done);
      chk("err", bus.o_err, e_err);
      chk("rf_we", bus.o_rf_we, e_we);
      chk("apsr", bus.o_apsr, m_apsr);
      chk("alu_sel", bus.o_alu_sel, in_exec ? p_sel : 3'b000);
      chk("alu_imm", bus.o_alu_imm, in_exec ? p_imm : 32'h0);
      chk("alu_rn", bus.o_alu_rn, in_exec ? p_rnv : 32'h0);
      if (e_we) begin
        chk("waddr", bus.o_rf_waddr, p_rd);
        chk("wdata", bus.o_rf_wdata, p_data);
      end
      if (bus.o_rf_we) begin
        wr_count++;
        last_wdata = bus.o_rf_wdata;
        last_waddr = bus.o_rf_waddr;
      end
      if (busy) begin
        if (cyc == p_ret) begin
          if (p_legal && !bus.i_abort) begin
            if (p_upd) m_apsr = p_apsr;
            if (p_we) mrf[p_rd] = p_data;
          end
          p_v = 0;
        end else if (bus.i_abort && p_legal) begin
          p_v = 0;
        end
      end
      if (e_ready && bus.i_valid) begin
        p_v     = 1;
        p_k     = cyc + 1;
        p_rd    = bus.i_rd;
        p_imm   = bus.i_imm;
        p_legal = (bus.i_op inside {ADD, SUB, MOVI, MOVR, CMP});
        p_rnv   = (bus.i_op == MOVI) ? 32'h0 : mrf[bus.i_rn];
        p_sel   = (bus.i_op == CMP) ? SUB : bus.i_op;
        rx      = ref_exec(bus.i_op, p_rnv, bus.i_imm);
        p_data  = rx[31:0];
        p_apsr  = rx[35:32];
        p_we    = p_legal && (bus.i_op != CMP);
        p_upd   = (bus.i_op inside {ADD, SUB, CMP});
        p_ret   = !p_legal ? p_k : (bus.i_op == MOVI) ? p_k + 1 : p_k + 2;
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rn,
                       input logic [31:0] imm, input int abort_off, input int rst_off);
    bit got = 0;
    @(posedge clk); #1;
    bus.i_valid = 1; bus.i_op = op; bus.i_rd = rd; bus.i_rn = rn; bus.i_imm = imm;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.o_ready) got = 1;
      else begin @(posedge clk); #1; end
    end
    if (!got) begin
      n_vec++; n_fail++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1 within 20 cycles");
      bus.i_valid = 0;
      return;
    end
    @(posedge clk); #1;
    bus.i_valid = 0;
    for (int off = 0; off < 4; off++) begin
      bus.i_abort = (off == abort_off);
      if (off == rst_off) rst_n = 0;
      @(posedge clk); #1;
    end
    bus.i_abort = 0;
    rst_n = 1;
  endtask

  initial begin
    int w0;
    logic [31:0] imm;
    rst_n = 0;
    bus.i_valid = 0; bus.i_op = '0; bus.i_rd = '0; bus.i_rn = '0; bus.i_imm = '0; bus.i_abort = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    issue(MOVI, 1, 0, 32'h5, -1, -1);
    chk("pin_movi_waddr", last_waddr, 1);
    chk("pin_movi_wdata", last_wdata, 32'h5);
    chk("pin_movi_apsr", bus.o_apsr, 4'b0000);

    issue(MOVI, 2, 0, 32'h3, -1, -1);
    issue(SUB, 3, 2, 32'h5, -1, -1);
    chk("pin_sub_wdata", last_wdata, 32'hFFFF_FFFE);
    chk("pin_sub_apsr", bus.o_apsr, 4'b1000);
    chk("pin_model_sub_apsr", m_apsr, 4'b1000);

    issue(MOVI, 5, 0, 32'hFFFF_FFFF, -1, -1);
    w0 = wr_count;
    issue(ADD, 6, 5, 32'h1, -1, -1);
    chk("pin_add_write", wr_count - w0, 1);
    chk("pin_add_wdata", last_wdata, 32'h0);
    chk("pin_add_apsr", bus.o_apsr, 4'b0110);

    issue(MOVI, 2, 0, 32'h7, -1, -1);
    w0 = wr_count;
    issue(CMP, 0, 2, 32'h7, -1, -1);
    chk("pin_cmp_nowrite", wr_count - w0, 0);
    chk("pin_cmp_apsr", bus.o_apsr, 4'b0110);
    issue(MOVR, 4, 2, 32'h0, -1, -1);
    chk("pin_movr_wdata", last_wdata, 32'h7);
    chk("pin_movr_apsr", bus.o_apsr, 4'b0110);

    w0 = wr_count;
    issue(3'b011, 1, 1, 32'h0, -1, -1);
    chk("pin_illegal_nowrite", wr_count - w0, 0);
    issue(3'b100, 1, 1, 32'h0, 0, -1);
    chk("pin_illegal_abort_apsr", bus.o_apsr, 4'b0110);

    w0 = wr_count;
    issue(ADD, 7, 2, 32'h1, 1, -1);
    issue(SUB, 7, 2, 32'h1, 2, -1);
    issue(MOVI, 7, 0, 32'h9, 0, -1);
    chk("pin_abort_nowrite", wr_count - w0, 0);

    issue(ADD, 7, 2, 32'h1, -1, 0);
    chk("pin_rst_apsr", bus.o_apsr, 4'b0000);

    @(posedge clk); #1;
    bus.i_valid = 1; bus.i_op = MOVI; bus.i_rd = 1; bus.i_imm = 32'h55; bus.i_abort = 1;
    repeat (5) @(posedge clk);
    #1 bus.i_valid = 0; bus.i_abort = 0;
    repeat (2) @(posedge clk);

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0: imm = 32'h0;
        1: imm = 32'hFFFF_FFFF;
        2: imm = 32'h7FFF_FFFF;
        3: imm = 32'h8000_0000;
        default: imm = $urandom;
      endcase
      issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), imm,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
            ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle execute-stage sequencer for the 32-bit integer ALU.
- Accepts one instruction per handshake.
- Reads the source operand from the external register file, drives the ALU select/operands and registers the ALU result and flags.
- Writes the result back, holds the architectural APSR and reports completion or illegal opcodes to the fetch/decode stage.

Parameters:
REG_AW, 3, register-file address width (2**REG_AW registers)

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_valid  in  1  instruction offered
o_ready  out  1  controller can accept an instruction this cycle
i_op  in  3  000 ADD, 101 SUB, 001 MOVI, 010 MOVR, 111 CMP; others illegal
i_rd  in  REG_AW  destination register
i_rn  in  REG_AW  source register
i_imm  in  32  immediate operand
i_abort  in  1  synchronous cancel of the in-flight instruction
o_rf_raddr  out  REG_AW  register-file read address; rdata valid one cycle later
i_rf_rdata  in  32  register-file read data
o_rf_we  out  1  write-back strobe, single cycle
o_rf_waddr  out  REG_AW  write-back address
o_rf_wdata  out  32  write-back data
o_alu_sel  out  3  ALU select: 000 add, 101 sub, 001 mov imm, 010 mov reg
o_alu_imm  out  32  ALU immediate operand
o_alu_rn  out  32  ALU register operand
i_alu_result  in  32  ALU result (combinational)
i_alu_apsr  in  4  ALU flags {N,Z,C,V}
o_apsr  out  4  architectural flags {N,Z,C,V}
o_done  out  1  one-cycle pulse when an instruction retires
o_err  out  1  one-cycle pulse on illegal opcode

Behaviour:
- Reset (async, i_rst_n=0):
  - state IDLE.
  - o_apsr=0, o_rf_we=0, o_done=0, o_err=0, o_ready=0 while reset is asserted.
  - All latched fields and operand registers are 0.
  - Reset mid-operation discards the instruction: no write-back, no flag change.
- FSM states: IDLE, READ, EXEC, WB, ERR.
- IDLE:
  - o_ready = !i_abort.
  - Accept when i_valid && o_ready; latch op, rd, rn, imm.
  - MOVI -> EXEC.
  - ADD/SUB/MOVR/CMP -> READ.
  - Illegal op -> ERR.
- READ: o_rf_raddr = latched rn (driven from accept onward); capture i_rf_rdata into operand register; -> EXEC.
- EXEC:
  - o_alu_sel = op (CMP maps to 101).
  - o_alu_imm = latched imm; o_alu_rn = operand register (0 for MOVI).
  - Capture i_alu_result and i_alu_apsr; -> WB.
- WB:
  - o_done=1.
  - o_rf_we=1 with o_rf_waddr=rd and o_rf_wdata=captured result, except CMP (we=0).
  - o_apsr <= captured flags for ADD, SUB, CMP; unchanged for MOVI, MOVR.
  - -> IDLE.
- ERR: o_err=1, no write, no flag change; -> IDLE.
- o_ready is 0 in every state except IDLE.
  - The next instruction is accepted on the cycle after WB/ERR, never in the same cycle.
- Latency, accept edge = k:
  - ADD/SUB/MOVR/CMP: o_done high in cycle k+3.
  - MOVI: o_done high in cycle k+2.
  - Illegal: o_err high in cycle k+1.
- i_abort:
  - In READ/EXEC/WB: next state IDLE; the WB-cycle write, flag update and o_done are suppressed that cycle (abort wins over retire).
  - In IDLE: blocks acceptance.
  - In ERR: o_err still pulses.
- o_alu_sel outputs 000 and operands are 0 outside EXEC.
- o_rf_we is never asserted outside WB.
- o_done and o_err are mutually exclusive.
- Arithmetic is done entirely by the ALU; 32-bit results wrap; the controller performs no width extension.
- rd == rn is legal: the read completes before write-back.
- Back-to-back dependency needs no forwarding (serial execution).

Test Plan:
- Reset then MOVI rd=1 imm=0x0000_0005 -> o_rf_we at k+2, waddr=1, wdata=5, o_apsr stays 0000, o_done one cycle.
- r2=0x0000_0003 (via MOVI), SUB rd=3 rn=2 imm=5 -> wdata=0xFFFF_FFFE at k+3, o_apsr[3]=1 (N).
- r2=7, CMP rn=2 imm=7 -> no o_rf_we, o_apsr[2]=1 (Z), o_done at k+3; then MOVR rd=4 rn=2 -> wdata=7, o_apsr unchanged.
- ADD rn=r with value 0xFFFF_FFFF, imm=1 -> wdata=0, Z set, write occurs.
- i_op=011 with i_valid -> o_err at k+1, no write, o_apsr unchanged, o_ready high at k+2.
- Abort and reset cases:
  - ADD accepted, i_abort in EXEC -> no write, no o_done, o_ready next cycle.
  - Repeat with i_rst_n low in READ -> outputs at reset values immediately.
  - i_valid held with i_abort in IDLE -> not accepted.
